gpio_logic_unit: RTL and testbench
==================================

// Module: gpio_logic_unit
// PURPOSE
// Parametrised, clocked GPIO logic/arithmetic unit for DE-series boards and DESim.
// Two W-bit operands arrive on the 40-pin header; the result and an auxiliary word are
// driven back onto the same header. SW selects one of 8 modes:
//   - four combinational ops, one add;
//   - three stateful modes stepped by a debounced KEY[1] press or by GPIO edges.
// Inputs are synchronised and outputs are registered, so the unit suits real headers.
// PARAMETERS
// W        8   operand/result width; GPIO width is 4*W
// PORTS
// CLOCK_50  in     1      system clock, all logic on rising edge
// KEY       in     4      KEY[0]: synchronous active-low reset; KEY[1]: step button (active-low); KEY[3:2] unused
// SW        in     10     SW[2:0] mode; SW[9] hold; SW[8:3] unused
// GPIO      inout  4*W    [W-1:0]=B in, [2W-1:W]=A in, [3W-1:2W]=R out, [4W-1:3W]=X out
// LEDR      out    10     [2:0] current synced mode, [9] sticky overflow, [8:3] = 0
// BEHAVIOUR
// - Pin directions:
//   - GPIO[2W-1:0] is permanently driven 'z.
//   - R and X are driven from registers.
// - Synchronisers:
//   - A, B, SW[2:0], SW[9] and KEY[1] each pass through 2 flops.
//   - Reset values are 0, except KEY[1] sync flops reset to 1 (unpressed).
// - Step pulse:
//   - 1 cycle wide, generated when synced KEY[1] goes 1->0.
//   - Held button = one step.
// - Latency:
//   - Input sampled at edge k is reflected in R/X/LEDR after edge k+2.
//   - A step from a KEY[1] fall at edge k updates state and R at edge k+2.
// - Reset (KEY[0]=0 at a rising edge): R, X, LEDR, ACC, CNT, SR, STEPS, OVF and the edge history all go to 0. Reset overrides every other event.
// - Modes (synced SW[2:0]):
//   - 0 pass: R=B, X=A
//   - 1 or: R=A|B, X=0
//   - 2 and: R=A&B, X=0
//   - 3 xor: R=A^B, X=0
//   - 4 add: R=(A+B) mod 2^W, X={W-1'b0,carry}; carry=1 sets OVF
//   - 5 accumulate:
//     - Each step: ACC<=ACC+A mod 2^W, STEPS<=STEPS+1 mod 2^W.
//     - R=ACC, X=STEPS. Wrap of ACC sets OVF.
//   - 6 edge count:
//     - Each rising edge of synced B[0]: CNT<=CNT+1 mod 2^W.
//     - R=CNT, X={W{CNT==A}}, using CNT after update.
//   - 7 shift:
//     - Each step: SR<={SR[W-2:0],B[0]}.
//     - R=SR, X=A.
// - Mode change: a change of synced mode clears ACC, STEPS, CNT, SR and OVF in that cycle. The clear wins over a simultaneous step or edge.
// - Hold (synced SW[9]=1):
//   - R, X, ACC, CNT, SR, STEPS and OVF freeze.
//   - Steps and B[0] edges are discarded.
//   - Edge/step history flops keep tracking, so releasing hold creates no spurious event.
// - OVF:
//   - Sticky until reset or mode change.
//   - LEDR[9]=OVF.
// - Counters wrap silently apart from OVF. No saturation.
// TESTING
// - Reset, then all inputs 0 -> R=X=LEDR=0; GPIO[15:0] reads z; no step after KEY[0] release.
// - Mode 3, A=8'hF0, B=8'h3C -> R=8'hCC exactly 3 edges after the inputs change.
// - Mode 4, A=8'hC8, B=8'h64 -> R=8'h2C, X=8'h01, LEDR[9]=1; then A=B=1 -> R=2, LEDR[9] stays 1.
// - Mode 5, A=8'h50, 4 KEY[1] presses (one held 100 cycles) -> R=8'h40, X=4, LEDR[9]=1.
// - Mode 6, A=3, 3 pulses on B[0] -> R=3, X=8'hFF; set SW[9] and pulse twice -> R stays 3.
// - Mode 7, shift in B[0]=1,0,1, switch to mode 5 in the same cycle as a step -> ACC=0, SR cleared.

Source files
------------

// File: rtl/gpio_logic_unit.sv
// rtl/gpio_logic_unit.sv - clocked GPIO logic/arithmetic unit with synchronised inputs
// and registered R/X/LEDR outputs.
module gpio_logic_unit #(
  parameter int W = 8
) (
  input  logic           CLOCK_50,
  input  logic [3:0]     KEY,
  input  logic [9:0]     SW,
  inout  wire  [4*W-1:0] GPIO,
  output logic [9:0]     LEDR
);

  logic rst_n;
  assign rst_n = KEY[0];

  logic unused_inputs;
  assign unused_inputs = ^{KEY[3:2], SW[8:3]};

  logic [W-1:0] a_s1_q, a_s2_q, b_s1_q, b_s2_q;
  logic [2:0]   mode_s1_q, mode_s2_q, mode_prev_q, led_mode_q;
  logic         hold_s1_q, hold_s2_q;
  logic         key_s1_q, key_s2_q, key_prev_q, b0_prev_q;

  logic [W-1:0] acc_q, steps_q, cnt_q, sr_q, r_q, x_q;
  logic [W-1:0] acc_d, steps_d, cnt_d, sr_d, r_d, x_d;
  logic         ovf_q, ovf_d;

  logic         step, rise, mode_chg;
  logic [W:0]   sum, acc_sum;

  assign step     = key_prev_q & ~key_s2_q;
  assign rise     = b_s2_q[0] & ~b0_prev_q;
  assign mode_chg = (mode_s2_q != mode_prev_q);
  assign sum      = {1'b0, a_s2_q} + {1'b0, b_s2_q};
  assign acc_sum  = {1'b0, acc_q} + {1'b0, a_s2_q};

  // Results are derived from the next-state values so a step or edge shows on R
  // in the same cycle the state moves.
  always_comb begin
    acc_d   = acc_q;
    steps_d = steps_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    ovf_d   = ovf_q;
    r_d     = '0;
    x_d     = '0;

    if (mode_chg) begin
      acc_d   = '0;
      steps_d = '0;
      cnt_d   = '0;
      sr_d    = '0;
      ovf_d   = 1'b0;
    end else begin
      case (mode_s2_q)
        3'd5: if (step) begin
          acc_d   = acc_sum[W-1:0];
          steps_d = steps_q + 1'b1;
          if (acc_sum[W]) ovf_d = 1'b1;
        end
        3'd6: if (rise) cnt_d = cnt_q + 1'b1;
        3'd7: if (step) sr_d = {sr_q[W-2:0], b_s2_q[0]};
        default: ;
      endcase
    end

    if (mode_s2_q == 3'd4 && sum[W]) ovf_d = 1'b1;

    case (mode_s2_q)
      3'd0: begin r_d = b_s2_q;          x_d = a_s2_q; end
      3'd1: begin r_d = a_s2_q | b_s2_q; x_d = '0;     end
      3'd2: begin r_d = a_s2_q & b_s2_q; x_d = '0;     end
      3'd3: begin r_d = a_s2_q ^ b_s2_q; x_d = '0;     end
      3'd4: begin r_d = sum[W-1:0];      x_d = {{(W-1){1'b0}}, sum[W]}; end
      3'd5: begin r_d = acc_d;           x_d = steps_d; end
      3'd6: begin r_d = cnt_d;           x_d = {W{cnt_d == a_s2_q}}; end
      default: begin r_d = sr_d;         x_d = a_s2_q; end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst_n) begin
      a_s1_q      <= '0;
      a_s2_q      <= '0;
      b_s1_q      <= '0;
      b_s2_q      <= '0;
      mode_s1_q   <= '0;
      mode_s2_q   <= '0;
      mode_prev_q <= '0;
      led_mode_q  <= '0;
      hold_s1_q   <= 1'b0;
      hold_s2_q   <= 1'b0;
      key_s1_q    <= 1'b1;
      key_s2_q    <= 1'b1;
      key_prev_q  <= 1'b0;
      b0_prev_q   <= 1'b0;
      acc_q       <= '0;
      steps_q     <= '0;
      cnt_q       <= '0;
      sr_q        <= '0;
      ovf_q       <= 1'b0;
      r_q         <= '0;
      x_q         <= '0;
    end else begin
      a_s1_q      <= GPIO[2*W-1:W];
      a_s2_q      <= a_s1_q;
      b_s1_q      <= GPIO[W-1:0];
      b_s2_q      <= b_s1_q;
      mode_s1_q   <= SW[2:0];
      mode_s2_q   <= mode_s1_q;
      hold_s1_q   <= SW[9];
      hold_s2_q   <= hold_s1_q;
      key_s1_q    <= KEY[1];
      key_s2_q    <= key_s1_q;
      // History keeps tracking through hold so its release creates no event.
      key_prev_q  <= key_s2_q;
      b0_prev_q   <= b_s2_q[0];
      mode_prev_q <= mode_s2_q;
      led_mode_q  <= mode_s2_q;
      if (!hold_s2_q) begin
        acc_q   <= acc_d;
        steps_q <= steps_d;
        cnt_q   <= cnt_d;
        sr_q    <= sr_d;
        ovf_q   <= ovf_d;
        r_q     <= r_d;
        x_q     <= x_d;
      end
    end
  end

  assign GPIO[2*W-1:0]   = {(2*W){1'bz}};
  assign GPIO[3*W-1:2*W] = r_q;
  assign GPIO[4*W-1:3*W] = x_q;
  assign LEDR            = {ovf_q, 6'b0, led_mode_q};

endmodule

// File: tb/tb_gpio_logic_unit.sv
// tb/tb_gpio_logic_unit.sv - directed self-checking bench for gpio_logic_unit.
module tb_gpio_logic_unit;

  localparam int W = 8;

  logic          clk = 1'b0;
  logic [3:0]    key;
  logic [9:0]    sw;
  logic [W-1:0]  a, b;
  wire  [4*W-1:0] gpio;
  logic [9:0]    ledr;
  int            errors = 0;
  int            checks = 0;

  assign gpio[2*W-1:0] = {a, b};

  gpio_logic_unit #(.W(W)) dut (
    .CLOCK_50(clk),
    .KEY(key),
    .SW(sw),
    .GPIO(gpio),
    .LEDR(ledr)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic press(input int held);
    key[1] = 1'b0;
    cyc(held);
    key[1] = 1'b1;
    cyc(4);
  endtask

  task automatic pulse_b0();
    b[0] = 1'b1;
    cyc(3);
    b[0] = 1'b0;
    cyc(3);
  endtask

  initial begin
    key = 4'b1110;
    sw  = '0;
    a   = '0;
    b   = '0;
    cyc(3);
    key[0] = 1'b1;
    cyc(1);
    chk("rst_r", gpio[3*W-1:2*W], 8'h00);
    chk("rst_x", gpio[4*W-1:3*W], 8'h00);
    chk("rst_ledr", ledr, 10'h000);
    cyc(6);
    chk("idle_r", gpio[3*W-1:2*W], 8'h00);
    chk("idle_ledr", ledr, 10'h000);

    // xor: result lands on the third edge after the inputs change
    sw = 10'd3; a = 8'hF0; b = 8'h3C;
    cyc(2);
    chk("xor_early", gpio[3*W-1:2*W], 8'h00);
    cyc(1);
    chk("xor_r", gpio[3*W-1:2*W], 8'hCC);
    chk("xor_x", gpio[4*W-1:3*W], 8'h00);
    chk("xor_ledr", ledr, 10'h003);

    sw = 10'd0; cyc(3);
    chk("pass_r", gpio[3*W-1:2*W], 8'h3C);
    chk("pass_x", gpio[4*W-1:3*W], 8'hF0);
    sw = 10'd1; cyc(3);
    chk("or_r", gpio[3*W-1:2*W], 8'hFC);
    sw = 10'd2; cyc(3);
    chk("and_r", gpio[3*W-1:2*W], 8'h30);

    sw = 10'd4; a = 8'h00; b = 8'h00; cyc(3);
    chk("add_zero_ledr", ledr, 10'h004);
    a = 8'hC8; b = 8'h64; cyc(3);
    chk("add_r", gpio[3*W-1:2*W], 8'h2C);
    chk("add_x", gpio[4*W-1:3*W], 8'h01);
    chk("add_ovf", ledr, 10'h204);
    a = 8'h01; b = 8'h01; cyc(3);
    chk("add2_r", gpio[3*W-1:2*W], 8'h02);
    chk("add2_x", gpio[4*W-1:3*W], 8'h00);
    chk("add2_ovf_sticky", ledr, 10'h204);

    sw = 10'd5; a = 8'h50; b = 8'h00; cyc(3);
    chk("acc_clr_ledr", ledr, 10'h005);
    chk("acc_clr_r", gpio[3*W-1:2*W], 8'h00);
    press(2);
    chk("acc1_r", gpio[3*W-1:2*W], 8'h50);
    press(100);
    chk("acc2_r", gpio[3*W-1:2*W], 8'hA0);
    chk("acc2_x", gpio[4*W-1:3*W], 8'h02);
    press(3);
    press(2);
    chk("acc_r", gpio[3*W-1:2*W], 8'h40);
    chk("acc_x", gpio[4*W-1:3*W], 8'h04);
    chk("acc_ovf", ledr, 10'h205);

    sw = 10'd6; a = 8'h03; b = 8'h00; cyc(3);
    chk("cnt_clr_ledr", ledr, 10'h006);
    pulse_b0(); pulse_b0(); pulse_b0();
    chk("cnt_r", gpio[3*W-1:2*W], 8'h03);
    chk("cnt_x", gpio[4*W-1:3*W], 8'hFF);
    sw = 10'h206; cyc(3);
    pulse_b0(); pulse_b0();
    chk("cnt_hold_r", gpio[3*W-1:2*W], 8'h03);
    chk("cnt_hold_x", gpio[4*W-1:3*W], 8'hFF);
    sw = 10'd6; cyc(5);
    chk("cnt_release_r", gpio[3*W-1:2*W], 8'h03);
    pulse_b0();
    chk("cnt_after_r", gpio[3*W-1:2*W], 8'h04);
    chk("cnt_after_x", gpio[4*W-1:3*W], 8'h00);

    sw = 10'd7; a = 8'h11; b = 8'h00; cyc(3);
    chk("sr_clr_r", gpio[3*W-1:2*W], 8'h00);
    chk("sr_x", gpio[4*W-1:3*W], 8'h11);
    b[0] = 1'b1; cyc(3); press(2);
    b[0] = 1'b0; cyc(3); press(2);
    b[0] = 1'b1; cyc(3); press(2);
    chk("sr_r", gpio[3*W-1:2*W], 8'h05);

    // mode change and step reach the synced domain on the same edge
    sw = 10'd5; key[1] = 1'b0;
    cyc(3);
    key[1] = 1'b1;
    cyc(4);
    chk("chg_acc_r", gpio[3*W-1:2*W], 8'h00);
    chk("chg_steps_x", gpio[4*W-1:3*W], 8'h00);
    chk("chg_ledr", ledr, 10'h005);
    press(2);
    chk("chg_next_r", gpio[3*W-1:2*W], 8'h11);
    chk("chg_next_x", gpio[4*W-1:3*W], 8'h01);

    key[0] = 1'b0; key[1] = 1'b0;
    cyc(1);
    chk("rst2_r", gpio[3*W-1:2*W], 8'h00);
    chk("rst2_x", gpio[4*W-1:3*W], 8'h00);
    chk("rst2_ledr", ledr, 10'h000);
    key = 4'b1111;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
